int_aggregator: RTL and testbench

- Collects up to 8 asynchronous peripheral interrupt requests and drives the single `int` line into the CPU interrupt controller.
- Per source: synchroniser, rising-edge capture into a pending bit, software mask.
- Provides PENDING, MASK and CAUSE registers on a small CPU register port.
- After software clears pending bits, `int` is forced low for a hold-off window, so the controller's repeat-prevention logic sees a low before any re-assertion.

---
 rtl/int_aggregator.sv | 174 +++++++++++++++++
 tb/tb_int_aggregator.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/int_aggregator.sv
// ---------------------------------------------------------------------------
// int_aggregator
//   Collects up to eight asynchronous peripheral interrupt requests into a
//   single registered interrupt line for the CPU interrupt controller.
//   Each source is synchronised, rising-edge captured into a pending bit and
//   gated by a software mask. PENDING, MASK and CAUSE registers are reachable
//   over a small strobe-based register port. Any write to PENDING forces the
//   interrupt line low for HOLDOFF cycles. This lets the controller see a low
//   before the line is asserted again.
//
// Parameters
//   N        number of request sources (1..8)
//   HOLDOFF  cycles the interrupt line stays low after a PENDING write (1..15)
//
// Ports
//   clk      system clock, all state on the rising edge
//   rst      asynchronous active-low reset
//   req      [N-1:0] asynchronous level requests, rising edge = new interrupt
//   addr     [1:0] register select: 0 PENDING, 1 MASK, 2 CAUSE, 3 reserved
//   we       write strobe
//   re       read strobe
//   wdata    [7:0] write data
//   rdata    [7:0] registered read data, holds when re is low
//   int_req  registered interrupt request to the controller
// ---------------------------------------------------------------------------
module int_aggregator #(
    parameter int N       = 8,
    parameter int HOLDOFF = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [1:0]   addr,
    input  logic         we,
    input  logic         re,
    input  logic [7:0]   wdata,
    output logic [7:0]   rdata,
    output logic         int_req
);

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_CAUSE   = 2'd2;
    localparam logic [3:0] HOLD_LOAD    = 4'(HOLDOFF);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [N-1:0] sync_s1;
    logic [N-1:0] sync_s2;
    logic [N-1:0] prev;
    logic [N-1:0] pending;
    logic [N-1:0] mask;
    logic [3:0]   hold;

    // -----------------------------------------------------------------------
    // Next-state terms
    // -----------------------------------------------------------------------
    logic         wr_pending;
    logic         wr_mask;
    logic [N-1:0] edge_det;
    logic [N-1:0] clear_bits;
    logic [N-1:0] pending_next;
    logic [N-1:0] mask_next;
    logic [3:0]   hold_next;
    logic         int_next;

    // Register read view, widened to the 8-bit bus
    logic [7:0]   pending_view;
    logic [7:0]   mask_view;
    logic [7:0]   active_view;
    logic [2:0]   low_index;
    logic [7:0]   cause_view;
    logic [7:0]   rd_mux;

    assign wr_pending = we && (addr == ADDR_PENDING);
    assign wr_mask    = we && (addr == ADDR_MASK);

    // prev resets to 0. A request that is still high when reset is released
    // therefore produces exactly one edge.
    assign edge_det   = sync_s2 & ~prev;

    assign clear_bits = wr_pending ? wdata[N-1:0] : '0;

    // A new edge wins over a simultaneous write-1-to-clear on the same bit.
    assign pending_next = edge_det | (pending & ~clear_bits);

    assign mask_next = wr_mask ? wdata[N-1:0] : mask;

    // Every PENDING write reloads the window, including an all-zero write and
    // a write made while the window is still running.
    always_comb begin
        hold_next = hold;
        if (wr_pending) begin
            hold_next = HOLD_LOAD;
        end else if (hold != 4'd0) begin
            hold_next = hold - 4'd1;
        end
    end

    // Evaluated on next-state values, so new edges, mask writes and the end
    // of the hold-off window show on the line at the same edge they land.
    assign int_next = (|(pending_next & mask_next)) && (hold_next == 4'd0);

    // -----------------------------------------------------------------------
    // Read path
    // -----------------------------------------------------------------------
    assign pending_view = 8'(pending);
    assign mask_view    = 8'(mask);
    assign active_view  = pending_view & mask_view;

    // Lowest-numbered active source. The loop runs downward, so the last
    // match it makes is the lowest index.
    always_comb begin
        low_index = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (active_view[i]) begin
                low_index = 3'(i);
            end
        end
    end

    assign cause_view = {|active_view, 4'b0000, low_index};

    always_comb begin
        rd_mux = 8'h00;
        case (addr)
            ADDR_PENDING: rd_mux = pending_view;
            ADDR_MASK:    rd_mux = mask_view;
            ADDR_CAUSE:   rd_mux = cause_view;
            default:      rd_mux = 8'h00;
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
            prev    <= '0;
        end else begin
            sync_s1 <= req;
            sync_s2 <= sync_s1;
            prev    <= sync_s2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            mask    <= '0;
            hold    <= 4'd0;
            int_req <= 1'b0;
        end else begin
            pending <= pending_next;
            mask    <= mask_next;
            hold    <= hold_next;
            int_req <= int_next;
        end
    end

    // Reads return pre-edge register values. A read and a clear of PENDING
    // in the same cycle therefore report the bits being cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= 8'h00;
        end else if (re) begin
            rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_int_aggregator.sv
module tb_int_aggregator;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [1:0] addr;
    logic       we;
    logic       re;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       int_req;

    int errors = 0;
    int checks = 0;

    bit int_chk = 1'b0;
    bit mon_r;
    bit mon_c;

    typedef struct {
        bit         is_read;
        logic [7:0] exp;
        string      nm;
    } item_t;

    item_t sb[$];

    int_aggregator #(.N(8), .HOLDOFF(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .addr    (addr),
        .we      (we),
        .re      (re),
        .wdata   (wdata),
        .rdata   (rdata),
        .int_req (int_req)
    );

    always #5 clk = ~clk;

    task automatic check_one(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic pop_check(input bit rd);
        item_t it;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got no expectation for %s output", rd ? "read" : "int");
        end else begin
            it = sb.pop_front();
            if (it.is_read != rd) begin
                checks++;
                errors++;
                $display("FAIL %s: got %s output expected %s output", it.nm,
                         rd ? "read" : "int", it.is_read ? "read" : "int");
            end else if (rd) begin
                check_one(it.nm, rdata, it.exp);
            end else begin
                check_one(it.nm, {7'b0, int_req}, it.exp);
            end
        end
    endtask

    // Monitor: strobes seen at an edge mean an output is due just after it.
    always begin
        @(posedge clk);
        mon_r = re;
        mon_c = int_chk;
        #1;
        if (mon_r) pop_check(1'b1);
        if (mon_c) pop_check(1'b0);
    end

    // One bus cycle, launched from a falling edge.
    task automatic step(input bit w, input bit r, input logic [1:0] a, input logic [7:0] d,
                        input logic [7:0] rexp, input bit ci, input bit iexp, input string nm);
        item_t it;
        we      = w;
        re      = r;
        addr    = a;
        wdata   = d;
        int_chk = ci;
        if (r) begin
            it.is_read = 1'b1; it.exp = rexp; it.nm = {nm, "_rd"};
            sb.push_back(it);
        end
        if (ci) begin
            it.is_read = 1'b0; it.exp = {7'b0, iexp}; it.nm = {nm, "_int"};
            sb.push_back(it);
        end
        @(negedge clk);
        we      = 1'b0;
        re      = 1'b0;
        int_chk = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string nm);
        step(1'b0, 1'b1, a, 8'h00, exp, 1'b0, 1'b0, nm);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d, input bit ci, input bit iexp, input string nm);
        step(1'b1, 1'b0, a, d, 8'h00, ci, iexp, nm);
    endtask

    task automatic ck(input bit iexp, input string nm);
        step(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, iexp, nm);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, "idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; req = 8'h00; addr = 2'd0; we = 1'b0; re = 1'b0; wdata = 8'h00;
        repeat (3) @(negedge clk);
        check_one("in_reset_int", {7'b0, int_req}, 8'h00);
        rst = 1'b1;

        // Reset state
        step(1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, "post_rst_pend");
        rd(2'd1, 8'h00, "post_rst_mask");
        rd(2'd2, 8'h00, "post_rst_cause");

        // Latency of a single edge
        wr(2'd1, 8'hFF, 1'b0, 1'b0, "mask_ff");
        req = 8'h08;
        ck(1'b0, "lat_e0");
        ck(1'b0, "lat_e1");
        ck(1'b1, "lat_e2");
        rd(2'd0, 8'h08, "pend_08");
        rd(2'd2, 8'h83, "cause_83");

        // Two sources, clear one, hold-off, then the other
        wr(2'd0, 8'h08, 1'b1, 1'b0, "clr08");
        ck(1'b0, "clr08_h1");
        ck(1'b0, "clr08_h2");
        req = 8'h2A;
        ck(1'b0, "two_e0");
        ck(1'b0, "two_e1");
        ck(1'b1, "two_e2");
        rd(2'd2, 8'h81, "cause_81");
        rd(2'd0, 8'h22, "pend_22");
        wr(2'd0, 8'h02, 1'b1, 1'b0, "clr02_w");
        ck(1'b0, "clr02_w1");
        ck(1'b1, "clr02_w2");
        rd(2'd2, 8'h85, "cause_85");
        wr(2'd0, 8'h20, 1'b1, 1'b0, "clr20_w");
        ck(1'b0, "clr20_w1");
        ck(1'b0, "clr20_w2");
        ck(1'b0, "clr20_w3");
        rd(2'd0, 8'h00, "pend_empty");

        // Masked-out source still sets pending; unmask raises int at once
        wr(2'd1, 8'h00, 1'b0, 1'b0, "mask_00");
        req = 8'h2B;
        ck(1'b0, "masked_e0");
        ck(1'b0, "masked_e1");
        ck(1'b0, "masked_e2");
        rd(2'd0, 8'h01, "pend_01");
        step(1'b0, 1'b1, 2'd2, 8'h00, 8'h00, 1'b1, 1'b0, "cause_masked");
        wr(2'd1, 8'h01, 1'b1, 1'b1, "unmask01");

        // Held request sets pending once only
        wr(2'd0, 8'h01, 1'b0, 1'b0, "clr01");
        wr(2'd1, 8'h04, 1'b0, 1'b0, "mask_04");
        idle(1);
        req = 8'h2F;
        ck(1'b0, "held_e0");
        ck(1'b0, "held_e1");
        ck(1'b1, "held_e2");
        idle(17);
        rd(2'd0, 8'h04, "held_pend");
        wr(2'd0, 8'h04, 1'b0, 1'b0, "held_clr");
        idle(4);
        step(1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, "held_noreset");
        req = 8'h2B;
        idle(3);
        req = 8'h2F;
        ck(1'b0, "rearm_e0");
        ck(1'b0, "rearm_e1");
        ck(1'b1, "rearm_e2");
        rd(2'd0, 8'h04, "rearm_pend");

        // Clear on the same edge as a new edge: set wins
        req = 8'h3F;
        idle(2);
        wr(2'd0, 8'h10, 1'b1, 1'b0, "setwins_w");
        rd(2'd0, 8'h14, "setwins_pend");
        step(1'b1, 1'b1, 2'd0, 8'h04, 8'h14, 1'b0, 1'b0, "rd_and_clr");
        rd(2'd0, 8'h10, "after_rdclr");
        wr(2'd2, 8'hFF, 1'b0, 1'b0, "wr_cause");
        rd(2'd1, 8'h04, "mask_keep");
        rd(2'd3, 8'h00, "addr3");
        rd(2'd0, 8'h10, "pend_10");

        // Async reset during hold-off
        wr(2'd0, 8'h00, 1'b1, 1'b0, "zero_wr");
        check_one("pre_rst_rdata", rdata, 8'h10);
        #2;
        rst = 1'b0;
        #1;
        check_one("async_rdata", rdata, 8'h00);
        check_one("async_int", {7'b0, int_req}, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Request held through reset release gives one edge
        ck(1'b0, "rel_e0");
        ck(1'b0, "rel_e1");
        ck(1'b0, "rel_e2");
        rd(2'd0, 8'h3F, "rel_pend");
        rd(2'd1, 8'h00, "rel_mask");
        rd(2'd2, 8'h00, "rel_cause");
        wr(2'd1, 8'h20, 1'b1, 1'b1, "rel_unmask");
        rd(2'd2, 8'h85, "rel_cause85");

        // A write inside the window restarts it
        wr(2'd0, 8'h00, 1'b1, 1'b0, "reload_w0");
        wr(2'd0, 8'h00, 1'b1, 1'b0, "reload_w1");
        ck(1'b0, "reload_w2");
        ck(1'b1, "reload_w3");

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain: got %0d left expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
